// File: rtl/dnn_eval_pkg.sv
// Shared constants and geometry helpers for the DNN output evaluator.
package dnn_eval_pkg;

    // Default geometry of the output stream.
    localparam int DEF_OUT_W     = 1;
    localparam int DEF_N_OUT     = 4;
    localparam int DEF_CPC       = 6;
    localparam int DEF_MAX_CASES = 100;
    localparam int DEF_CNT_W     = 16;

    // Index width and valid-beat count for the default geometry.
    localparam int IDX_W = $clog2(DEF_CPC);
    localparam int BEATS = DEF_CPC - 2;

    // Width of a modulo-cpc index.
    function automatic int idx_width(input int cpc);
        return (cpc <= 2) ? 1 : $clog2(cpc);
    endfunction

    // Number of valid beats in one case; the first two clocks are pipeline fill.
    function automatic int beat_count(input int cpc);
        return cpc - 2;
    endfunction

    // A case must carry exactly one output vector in its valid beats.
    function automatic bit geometry_ok(input int out_w, input int n_out, input int cpc);
        return (cpc >= 3) && (n_out == out_w * beat_count(cpc));
    endfunction

endpackage

// File: rtl/dnn_output_evaluator_if.sv
// Output-layer stream in, per-case report out.
interface dnn_output_evaluator_if
    import dnn_eval_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int N_OUT = DEF_N_OUT
);
    logic [OUT_W-1:0] a_out;
    logic [OUT_W-1:0] y_out;
    logic             case_done;
    logic             case_error;
    logic [N_OUT-1:0] case_pred;
    logic [N_OUT-1:0] case_ideal;

    // Stream source (the DNN) side.
    modport master (
        output a_out, y_out,
        input  case_done, case_error, case_pred, case_ideal
    );

    // Evaluator side.
    modport slave (
        input  a_out, y_out,
        output case_done, case_error, case_pred, case_ideal
    );
endinterface

// File: rtl/eval_beat_counter.sv
// Position within the current case; flags valid and last beats.
module eval_beat_counter
    import dnn_eval_pkg::*;
#(
    parameter int CPC   = DEF_CPC,
    parameter int IDX_W = idx_width(CPC)
) (
    input  logic             clk,
    input  logic             reset,
    output logic [IDX_W-1:0] cycle_index,
    output logic             beat_valid,
    output logic             last_beat
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CPC - 1);
    localparam logic [IDX_W-1:0] FIRST_VLD = IDX_W'(2);

    // Modulo-CPC count, restarting at 0 after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_index <= '0;
        end else if (cycle_index == LAST_IDX) begin
            cycle_index <= '0;
        end else begin
            cycle_index <= cycle_index + 1'b1;
        end
    end

    assign beat_valid = (cycle_index >= FIRST_VLD);
    assign last_beat  = (cycle_index == LAST_IDX);

endmodule

// File: rtl/dnn_output_evaluator.sv
// Reassembles per-case predicted/ideal vectors from the output stream,
// flags mismatching cases and keeps case/error statistics.
module dnn_output_evaluator
    import dnn_eval_pkg::*;
#(
    parameter int OUT_W     = DEF_OUT_W,
    parameter int N_OUT     = DEF_N_OUT,
    parameter int CPC       = DEF_CPC,
    parameter int MAX_CASES = DEF_MAX_CASES,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    dnn_output_evaluator_if.slave     stream,
    input  logic                      clear_stats,
    output logic [idx_width(CPC)-1:0] cycle_index,
    output logic [CNT_W-1:0]          num_cases,
    output logic [CNT_W-1:0]          total_error,
    output logic                      done
);

    localparam bit               FREEZE_EN = (MAX_CASES != 0);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CASES);
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;

    generate
        if (!geometry_ok(OUT_W, N_OUT, CPC)) begin : g_bad_geometry
            $error("dnn_output_evaluator: need CPC >= 3 and N_OUT == OUT_W*(CPC-2)");
        end
    endgenerate

    logic             beat_valid;
    logic             last_beat;
    logic [N_OUT-1:0] pred_sr;
    logic [N_OUT-1:0] ideal_sr;
    logic [N_OUT-1:0] pred_next;
    logic [N_OUT-1:0] ideal_next;
    logic             err_acc;
    logic             beat_err;
    logic             case_err_next;
    logic             frozen;
    logic [CNT_W-1:0] num_inc;
    logic [CNT_W-1:0] err_inc;

    eval_beat_counter #(
        .CPC   (CPC),
        .IDX_W (idx_width(CPC))
    ) u_beat_counter (
        .clk         (clk),
        .reset       (reset),
        .cycle_index (cycle_index),
        .beat_valid  (beat_valid),
        .last_beat   (last_beat)
    );

    // MSB slice arrives first, so each new slice enters at the bottom.
    assign pred_next     = N_OUT'({pred_sr, stream.a_out});
    assign ideal_next    = N_OUT'({ideal_sr, stream.y_out});
    assign beat_err      = (stream.a_out != stream.y_out);
    assign case_err_next = err_acc | beat_err;
    assign frozen        = FREEZE_EN && (num_cases == MAX_C);

    // Saturating increments for the statistics counters.
    always_comb begin
        num_inc = num_cases;
        err_inc = total_error;
        if (num_cases != CNT_SAT) begin
            num_inc = num_cases + 1'b1;
        end
        if (case_err_next && (total_error != CNT_SAT)) begin
            err_inc = total_error + 1'b1;
        end
    end

    // Assembly, error accumulation and the per-case report.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pred_sr           <= '0;
            ideal_sr          <= '0;
            err_acc           <= 1'b0;
            stream.case_done  <= 1'b0;
            stream.case_error <= 1'b0;
            stream.case_pred  <= '0;
            stream.case_ideal <= '0;
        end else begin
            if (beat_valid) begin
                pred_sr  <= pred_next;
                ideal_sr <= ideal_next;
                err_acc  <= case_err_next;
            end
            stream.case_done <= last_beat;
            if (last_beat) begin
                stream.case_pred  <= pred_next;
                stream.case_ideal <= ideal_next;
                stream.case_error <= case_err_next;
                err_acc           <= 1'b0;
            end
        end
    end

    // Case/error statistics; clear overrides a coinciding case completion.
    always_ff @(posedge clk) begin
        if (!reset) begin
            num_cases   <= '0;
            total_error <= '0;
            done        <= 1'b0;
        end else if (clear_stats) begin
            num_cases   <= '0;
            total_error <= '0;
            done        <= 1'b0;
        end else if (last_beat && !frozen) begin
            num_cases   <= num_inc;
            total_error <= err_inc;
            done        <= FREEZE_EN && (num_inc == MAX_C);
        end
    end

endmodule
